// File: rtl/priv_trap_ctrl_pkg.sv
// machine_mode_types_1_12_pkg: trap controller state/kind types, cause codes and defaults.
package machine_mode_types_1_12_pkg;
    localparam int NUM_EXTENSIONS = 4;
    localparam int RMGMT_BASE_DEFAULT = 24;
    typedef logic [1:0] trap_state_t;
    localparam trap_state_t IDLE = 2'd0;
    localparam trap_state_t DRAIN = 2'd1;
    localparam trap_state_t REDIRECT = 2'd2;
    typedef enum logic [1:0] {EXC, INT, RET} trap_kind_t;
    localparam logic [31:0] CAUSE_MAL_INSN = 32'd0;
    localparam logic [31:0] CAUSE_FAULT_INSN = 32'd1;
    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
    localparam logic [31:0] CAUSE_MAL_L = 32'd4;
    localparam logic [31:0] CAUSE_FAULT_L = 32'd5;
    localparam logic [31:0] CAUSE_MAL_S = 32'd6;
    localparam logic [31:0] CAUSE_FAULT_S = 32'd7;
    localparam logic [31:0] CAUSE_ENV_M = 32'd11;
    localparam logic [31:0] IRQ_SOFT = 32'd3;
    localparam logic [31:0] IRQ_TIMER = 32'd7;
    localparam logic [31:0] IRQ_EXT = 32'd11;
    function automatic int cause_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/priv_trap_ctrl_if.sv
// priv_trap_ctrl_if: hazard unit (master) <-> priv trap controller (slave) request/redirect bundle.
interface priv_trap_ctrl_if import machine_mode_types_1_12_pkg::*; #(
    parameter int NUM_EXT = NUM_EXTENSIONS
);
    logic fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s, breakpoint, env_m;
    logic ret;
    logic pipe_clear;
    logic [31:0] epc;
    logic [31:0] badaddr;
    logic ex_rmgmt;
    logic [cause_w(NUM_EXT)-1:0] ex_rmgmt_cause;
    logic intr;
    logic insert_pc;
    logic [31:0] priv_pc;
    modport master (
        output fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s, breakpoint, env_m,
        output ret, pipe_clear, epc, badaddr, ex_rmgmt, ex_rmgmt_cause,
        input intr, insert_pc, priv_pc
    );
    modport slave (
        input fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s, breakpoint, env_m,
        input ret, pipe_clear, epc, badaddr, ex_rmgmt, ex_rmgmt_cause,
        output intr, insert_pc, priv_pc
    );
endinterface

// File: rtl/priv_trap_ctrl_prio.sv
// priv_trap_prio: combinational pick of the winning exception/interrupt/ret and its mcause.
module priv_trap_prio import machine_mode_types_1_12_pkg::*; #(
    parameter int NUM_EXT = NUM_EXTENSIONS,
    parameter int RMGMT_BASE = RMGMT_BASE_DEFAULT
) (
    input logic breakpoint, fault_insn, mal_insn, illegal_insn, env_m,
    input logic mal_s, mal_l, fault_s, fault_l,
    input logic ex_rmgmt,
    input logic [cause_w(NUM_EXT)-1:0] ex_rmgmt_cause,
    input logic ext_int, soft_int, timer_int, mie_global,
    input logic ret,
    output logic valid,
    output trap_kind_t kind,
    output logic [31:0] mcause,
    output logic tval_sel
);
    logic exc, irq;
    logic [31:0] exc_cause, irq_cause;
    assign exc = breakpoint | fault_insn | mal_insn | illegal_insn | env_m
               | mal_s | mal_l | fault_s | fault_l | ex_rmgmt;
    assign irq = mie_global & (ext_int | soft_int | timer_int);
    assign exc_cause = breakpoint   ? CAUSE_BREAKPOINT :
                       fault_insn   ? CAUSE_FAULT_INSN :
                       mal_insn     ? CAUSE_MAL_INSN :
                       illegal_insn ? CAUSE_ILLEGAL :
                       env_m        ? CAUSE_ENV_M :
                       mal_s        ? CAUSE_MAL_S :
                       mal_l        ? CAUSE_MAL_L :
                       fault_s      ? CAUSE_FAULT_S :
                       fault_l      ? CAUSE_FAULT_L :
                                      32'(RMGMT_BASE) + 32'(ex_rmgmt_cause);
    assign irq_cause = ext_int ? IRQ_EXT : soft_int ? IRQ_SOFT : IRQ_TIMER;
    assign valid = exc | irq | ret;
    assign kind = exc ? EXC : irq ? INT : RET;
    assign mcause = exc ? exc_cause : irq ? (32'h8000_0000 | irq_cause) : 32'd0;
    // only address-type faults carry badaddr; higher-priority non-address causes mask them
    assign tval_sel = exc & ~breakpoint & (fault_insn | mal_insn
                    | (~illegal_insn & ~env_m & (mal_s | mal_l | fault_s | fault_l)));
endmodule

// File: rtl/priv_trap_ctrl.sv
// priv_trap_ctrl: trap/xRET sequencer (IDLE->DRAIN->REDIRECT) driving CSR strobes and pc redirect.
// Optional `VECTORED_TRAP_EN: interrupts vector off mtvec when mtvec[1:0]==2'b01.
module priv_trap_ctrl import machine_mode_types_1_12_pkg::*; #(
    parameter int NUM_EXT = NUM_EXTENSIONS,
    parameter int RMGMT_BASE = RMGMT_BASE_DEFAULT
) (
    input logic CLK,
    input logic nRST,
    priv_trap_ctrl_if.slave tif,
    input logic ext_int,
    input logic soft_int,
    input logic timer_int,
    input logic mie_global,
    input logic [31:0] mtvec,
    input logic [31:0] mepc_r,
    output logic mepc_wen,
    output logic mcause_wen,
    output logic mtval_wen,
    output logic [31:0] mepc_wdata,
    output logic [31:0] mcause_wdata,
    output logic [31:0] mtval_wdata,
    output logic mstatus_push,
    output logic mstatus_pop
);
    trap_state_t state, state_n;
    trap_kind_t kind_q, p_kind;
    logic [31:0] cause_q, epc_q, tval_q, p_mcause, base, trap_pc;
    logic p_valid, p_tval_sel, commit;
    priv_trap_prio #(.NUM_EXT(NUM_EXT), .RMGMT_BASE(RMGMT_BASE)) u_prio (
        .breakpoint(tif.breakpoint), .fault_insn(tif.fault_insn), .mal_insn(tif.mal_insn),
        .illegal_insn(tif.illegal_insn), .env_m(tif.env_m), .mal_s(tif.mal_s),
        .mal_l(tif.mal_l), .fault_s(tif.fault_s), .fault_l(tif.fault_l),
        .ex_rmgmt(tif.ex_rmgmt), .ex_rmgmt_cause(tif.ex_rmgmt_cause),
        .ext_int(ext_int), .soft_int(soft_int), .timer_int(timer_int),
        .mie_global(mie_global), .ret(tif.ret),
        .valid(p_valid), .kind(p_kind), .mcause(p_mcause), .tval_sel(p_tval_sel)
    );
    assign state_n = (state == IDLE)  ? (p_valid ? DRAIN : IDLE) :
                     (state == DRAIN) ? (tif.pipe_clear ? REDIRECT : DRAIN) : IDLE;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            kind_q <= EXC;
            cause_q <= '0;
            epc_q <= '0;
            tval_q <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && p_valid) begin
                kind_q <= p_kind;
                cause_q <= p_mcause;
                epc_q <= tif.epc;
                tval_q <= p_tval_sel ? tif.badaddr : '0;
            end
        end
    end
    assign commit = (state == DRAIN) && tif.pipe_clear;
    assign mepc_wen = commit && kind_q != RET;
    assign mcause_wen = mepc_wen;
    assign mtval_wen = mepc_wen;
    assign mstatus_push = mepc_wen;
    assign mstatus_pop = commit && kind_q == RET;
    assign mepc_wdata = epc_q;
    assign mcause_wdata = cause_q;
    assign mtval_wdata = tval_q;
    assign tif.intr = state != IDLE;
    assign tif.insert_pc = state == REDIRECT;
    assign base = mtvec & ~32'd3;
`ifdef VECTORED_TRAP_EN
    assign trap_pc = (kind_q == INT && mtvec[1:0] == 2'b01) ? base + {25'd0, cause_q[4:0], 2'b00} : base;
`else
    assign trap_pc = base;
`endif
    assign tif.priv_pc = tif.insert_pc ? (kind_q == RET ? mepc_r : trap_pc) : '0;
endmodule
